// File: rtl/arb_check_pkg.sv
// Shared constants and helpers for the arbiter protocol checker.
// Optional starvation rule is enabled with the ARB_CHECK_STARVE_EN macro.
package arb_check_pkg;

    // Bit positions of each rule inside err_flags.
    localparam int R_ONEHOT     = 0;
    localparam int R_GRANT_REQ  = 1;
    localparam int R_NO_PREEMPT = 2;
    localparam int R_RELEASE    = 3;
    localparam int R_PRIORITY   = 4;
    localparam int R_IDLE       = 5;
    localparam int R_STARVE     = 6;

    localparam int ERR_W = 32;
    localparam int MAX_W = 256;

`ifdef ARB_CHECK_STARVE_EN
    localparam int FLAG_W = 7;
`else
    localparam int FLAG_W = 6;
`endif

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int lowest_set(input logic [MAX_W-1:0] vec);
        lowest_set = 0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = i;
        end
    endfunction

endpackage

// File: rtl/arb_check_wait.sv
// Per-requester wait counter for starvation detection.
// Only present in builds that define ARB_CHECK_STARVE_EN.
`ifdef ARB_CHECK_STARVE_EN
module arb_check_wait #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic waiting,
    output logic hit
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Fires on the cycle the count reaches TIMEOUT; saturation keeps it single-shot.
    assign hit = active && waiting && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (active) begin
            if (!waiting) begin
                cnt <= '0;
            end else if (cnt != CW'(TIMEOUT)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/arb_check.sv
// Request/grant protocol checker for the priority arbiter (bit 0 = highest priority).
// Define ARB_CHECK_STARVE_EN to add per-requester starvation checking (err_flags bit 6).
module arb_check
    import arb_check_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LAT     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         req,
    input  logic [WIDTH-1:0]         grt,
    output logic [ERR_W-1:0]         errors,
    output logic [FLAG_W-1:0]        err_flags,
    output logic                     err_pulse,
    output logic [$clog2(WIDTH)-1:0] err_id
);

    localparam int ID_W   = $clog2(WIDTH);
    localparam int IDLE_W = $clog2(LAT + 2);

    logic [WIDTH-1:0]  req_q;
    logic [WIDTH-1:0]  grt_q;
    logic              vld_q;
    logic [IDLE_W-1:0] idle_cnt;

    logic              active;
    logic              idle;
    logic [WIDTH-1:0]  prio_exp;
    logic [WIDTH-1:0]  v_onehot;
    logic [WIDTH-1:0]  v_grant_req;
    logic [WIDTH-1:0]  v_preempt;
    logic [WIDTH-1:0]  v_release;
    logic [WIDTH-1:0]  v_prio;
    logic [WIDTH-1:0]  v_idle;
    logic [WIDTH-1:0]  id_vec;
    logic [FLAG_W-1:0] rule_hit;
    logic              any_hit;
    logic [ID_W-1:0]   id_next;

    assign active = en && vld_q;

    // The arbiter registers its grant, so idle time is judged against last cycle's request.
    assign idle     = (grt == '0) && (req_q != '0);
    assign prio_exp = req_q & (~req_q + WIDTH'(1));

    always_comb begin
        v_onehot    = ((grt & (grt - WIDTH'(1))) != '0) ? grt : '0;
        v_grant_req = grt & ~grt_q & ~req_q;
        v_preempt   = grt_q & req_q & ~grt;
        v_release   = grt_q & ~req_q & grt;
        v_prio      = ((grt_q == '0) && (grt != '0)) ? (grt ^ prio_exp) : '0;
        v_idle      = (idle && (idle_cnt == IDLE_W'(LAT))) ? req_q : '0;
    end

`ifdef ARB_CHECK_STARVE_EN
    logic [WIDTH-1:0] starve_hit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_wait
        arb_check_wait #(
            .TIMEOUT(TIMEOUT)
        ) u_wait (
            .clk    (clk),
            .rst_n  (rst_n),
            .active (active),
            .waiting(req[i] & ~grt[i]),
            .hit    (starve_hit[i])
        );
    end
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;
`endif

    always_comb begin
        rule_hit               = '0;
        rule_hit[R_ONEHOT]     = active && (v_onehot != '0);
        rule_hit[R_GRANT_REQ]  = active && (v_grant_req != '0);
        rule_hit[R_NO_PREEMPT] = active && (v_preempt != '0);
        rule_hit[R_RELEASE]    = active && (v_release != '0);
        rule_hit[R_PRIORITY]   = active && (v_prio != '0);
        rule_hit[R_IDLE]       = active && (v_idle != '0);
        id_vec = v_onehot | v_grant_req | v_preempt | v_release | v_prio | v_idle;
`ifdef ARB_CHECK_STARVE_EN
        rule_hit[R_STARVE]     = starve_hit != '0;
        id_vec                 = id_vec | starve_hit;
`endif
    end

    assign any_hit = rule_hit != '0;
    assign id_next = ID_W'(lowest_set(MAX_W'(id_vec)));

    // Sample registers run even while checking is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            grt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            req_q <= req;
            grt_q <= grt;
            vld_q <= 1'b1;
        end
    end

    // Saturates at LAT+1 so an idle episode reports once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (active) begin
            if (!idle) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(LAT + 1)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errors    <= '0;
            err_flags <= '0;
            err_pulse <= 1'b0;
            err_id    <= '0;
        end else begin
            err_pulse <= any_hit;
            err_flags <= err_flags | rule_hit;
            if (any_hit) begin
                err_id <= id_next;
                if (errors != '1) errors <= errors + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_arb_check.sv
// Table-driven bench for arb_check with WIDTH=4, LAT=2, TIMEOUT=8.
// Each row drives one cycle; its expected outputs go through a scoreboard queue.
module tb_arb_check;
    import arb_check_pkg::*;

    localparam int WIDTH   = 4;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 2;
    localparam int EXP_W   = ERR_W + FLAG_W + 1 + ID_W;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [WIDTH-1:0]  req;
    logic [WIDTH-1:0]  grt;
    logic [ERR_W-1:0]  errors;
    logic [FLAG_W-1:0] err_flags;
    logic              err_pulse;
    logic [ID_W-1:0]   err_id;

    arb_check #(
        .WIDTH  (WIDTH),
        .LAT    (LAT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .grt      (grt),
        .errors   (errors),
        .err_flags(err_flags),
        .err_pulse(err_pulse),
        .err_id   (err_id)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                rst_before;
        bit                rst_after;
        logic              en;
        logic [WIDTH-1:0]  req;
        logic [WIDTH-1:0]  grt;
        logic [ERR_W-1:0]  errors;
        logic [FLAG_W-1:0] flags;
        logic              pulse;
        logic [ID_W-1:0]   id;
    } vec_t;

    vec_t tbl[$];
    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic add(input bit rb, input bit ra, input bit e, input logic [3:0] r,
                       input logic [3:0] g, input int er, input int fl, input bit p, input int id);
        vec_t v;
        v.rst_before = rb;
        v.rst_after  = ra;
        v.en         = e;
        v.req        = r;
        v.grt        = g;
        v.errors     = ERR_W'(er);
        v.flags      = FLAG_W'(fl);
        v.pulse      = p;
        v.id         = ID_W'(id);
        tbl.push_back(v);
    endtask

    task automatic compare(input string name, input int row, input logic [EXP_W-1:0] exp_v);
        logic [EXP_W-1:0] got;
        got = {errors, err_flags, err_pulse, err_id};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s row=%0d got errors=%0d flags=%b pulse=%b id=%0d exp errors=%0d flags=%b pulse=%b id=%0d",
                     name, row, errors, err_flags, err_pulse, err_id,
                     exp_v[EXP_W-1 -: ERR_W], exp_v[ID_W+1 +: FLAG_W], exp_v[ID_W], exp_v[ID_W-1:0]);
        end
    endtask

    // Driver: one row per cycle, inputs changed on the falling edge.
    task automatic apply(input int row, input vec_t v);
        if (v.rst_before) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            compare("reset_clear", row, '0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
        end
        en  = v.en;
        req = v.req;
        grt = v.grt;
        exp_q.push_back({v.errors, v.flags, v.pulse, v.id});
        @(posedge clk);
        #1;
        compare("row", row, exp_q.pop_front());
        if (v.rst_after) begin
            #2;
            rst_n = 1'b0;
            #1;
            compare("midcycle_reset", row, '0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = '0;
        grt   = '0;
        #12;
        compare("reset_state", -1, '0);

        // Legal traffic: grant bit 1, hold, drop request, hand over to bit 2.
        add(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0110, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0110, 4'b0010, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0110, 4'b0010, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0110, 4'b0010, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0100, 4'b0010, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0100, 4'b0100, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0000, 4'b0100, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // Two-hot grant: R1 plus R5, single increment, one-cycle pulse.
        add(0, 0, 1, 4'b0011, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0000, 4'b0011, 1, 17, 1, 0);
        add(0, 0, 1, 4'b0000, 4'b0000, 1, 17, 0, 0);
        add(0, 0, 1, 4'b0000, 4'b0000, 1, 17, 0, 0);
        // Priority: req_q=1010 granted 1000.
        add(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b1010, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b1010, 4'b1000, 1, 16, 1, 1);
        add(0, 0, 1, 4'b0000, 4'b1000, 1, 16, 0, 1);
        add(0, 0, 1, 4'b0000, 4'b0000, 1, 16, 0, 1);
        // Idle latency: grant withheld 5 cycles, one R6 on the 4th.
        add(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0001, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0001, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0001, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0001, 4'b0000, 1, 32, 1, 0);
        add(0, 0, 1, 4'b0001, 4'b0000, 1, 32, 0, 0);
        add(0, 0, 1, 4'b0001, 4'b0001, 1, 32, 0, 0);
        add(0, 0, 1, 4'b0000, 4'b0001, 1, 32, 0, 0);
        add(0, 0, 1, 4'b0000, 4'b0000, 1, 32, 0, 0);
        // Preemption 0100 -> 0001 with req[2] held, then reset mid-cycle.
        add(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0100, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0101, 4'b0100, 0, 0, 0, 0);
        add(0, 1, 1, 4'b0101, 4'b0001, 1, 4, 1, 2);
        // Checking resumes on the second clock; then en=0 masks a violation.
        add(1, 0, 1, 4'b0001, 4'b0011, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0001, 4'b0011, 1, 9, 1, 0);
        add(0, 0, 1, 4'b0001, 4'b0011, 2, 9, 1, 0);
        add(0, 0, 0, 4'b0000, 4'b0011, 2, 9, 0, 0);
        add(0, 0, 1, 4'b0000, 4'b0000, 2, 9, 0, 0);
`ifdef ARB_CHECK_STARVE_EN
        // Starvation: req[3] waits while bit 0 keeps the grant.
        add(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b1001, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 0, 1, 4'b1001, 4'b0001, 0, 0, 0, 0);
        add(0, 0, 1, 4'b1001, 4'b0001, 1, 64, 1, 3);
        add(0, 0, 1, 4'b1001, 4'b0001, 1, 64, 0, 3);
        add(0, 0, 1, 4'b1001, 4'b0001, 1, 64, 0, 3);
`endif

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
